// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write arbiter: AW/W routed by grant, B routed via grant FIFO.
// Define AXI_ARB_FIXED_PRIO_EN for fixed-priority selection (default: round-robin).
module axi_wr_arbiter #(
  parameter  int WIDTH       = 32,
  parameter  int SIZE        = 3,
  parameter  int NUM_MASTERS = 2,
  parameter  int OUTSTANDING = 4,
  localparam int IW          = WIDTH / 8,
  localparam int AWW         = 2 * IW + WIDTH + SIZE + SIZE - 1,
  localparam int WW          = WIDTH + IW + 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_MASTERS-1:0]     s_awvalid,
  output logic [NUM_MASTERS-1:0]     s_awready,
  input  logic [NUM_MASTERS*AWW-1:0] s_aw,
  input  logic [NUM_MASTERS-1:0]     s_wvalid,
  output logic [NUM_MASTERS-1:0]     s_wready,
  input  logic [NUM_MASTERS*WW-1:0]  s_w,
  output logic [NUM_MASTERS-1:0]     s_bvalid,
  input  logic [NUM_MASTERS-1:0]     s_bready,
  output logic [2*NUM_MASTERS-1:0]   s_bresp,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [AWW-1:0]             m_aw,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [WW-1:0]              m_w,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_sel;
  logic             w_req;
  logic [AWW-1:0]   r_aw;
  logic             w_start;
  logic             w_aw_hs;
  logic             w_wlast_hs;

  logic [GW-1:0]    r_fifo [OUTSTANDING];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [GW-1:0]    w_head;

  logic [AWW-1:0]   w_aw_arr [NUM_MASTERS];
  logic [WW-1:0]    w_w_arr  [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
    assign w_aw_arr[gi] = s_aw[gi*AWW +: AWW];
    assign w_w_arr[gi]  = s_w[gi*WW +: WW];
  end

  assign w_req   = |s_awvalid;
  assign w_full  = (r_cnt == CW'(OUTSTANDING));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rp];
  assign w_push  = w_aw_hs;
  assign w_pop   = m_bvalid && m_bready;

  assign m_awvalid = (r_state == S_ADDR);
  assign m_aw      = r_aw;

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    w_sel = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (s_awvalid[GW'(k)]) w_sel = GW'(k);
    end
  end
`else
  logic [GW-1:0] r_last;

  // Round-robin: first requester after the last grant, wrapping.
  always_comb begin
    logic [GW:0] v_idx;
    v_idx = '0;
    w_sel = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      v_idx = {1'b0, r_last} + (GW+1)'(k);
      if (v_idx >= (GW+1)'(NUM_MASTERS))
        v_idx = v_idx - (GW+1)'(NUM_MASTERS);
      if (s_awvalid[v_idx[GW-1:0]]) w_sel = v_idx[GW-1:0];
    end
  end

  // Last-grant pointer for the round-robin search.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= GW'(NUM_MASTERS - 1);
    end else if (w_start) begin
      r_last <= w_sel;
    end
  end
`endif

  // FSM next-state and handshake strobes.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_aw_hs    = 1'b0;
    w_wlast_hs = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && !w_full) begin
          w_start = 1'b1;
          w_next  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_awready) begin
          w_aw_hs = 1'b1;
          w_next  = S_DATA;
        end
      end
      S_DATA: begin
        if (m_wvalid && m_wready && m_w[0]) begin
          w_wlast_hs = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture grant and its AW payload on selection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant <= '0;
      r_aw    <= '0;
    end else if (w_start) begin
      r_grant <= w_sel;
      r_aw    <= w_aw_arr[w_sel];
    end
  end

  // AW ready and W mux toward the granted master.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    m_wvalid  = 1'b0;
    m_w       = '0;
    if (r_state == S_ADDR) begin
      s_awready[r_grant] = m_awready;
    end
    if (r_state == S_DATA) begin
      m_wvalid          = s_wvalid[r_grant];
      m_w               = w_w_arr[r_grant];
      s_wready[r_grant] = m_wready;
    end
  end

  // B response routed to the oldest outstanding master.
  always_comb begin
    s_bvalid = '0;
    s_bresp  = '0;
    m_bready = 1'b0;
    if (!w_empty) begin
      s_bvalid[w_head]            = m_bvalid;
      s_bresp[{w_head, 1'b0} +: 2] = m_bresp;
      m_bready                    = s_bready[w_head];
    end
  end

  // Grant FIFO storage and pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= r_grant;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Occupancy: push and pop together cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
